// File: rtl/crc32_chk.sv
// rtl/crc32_chk.sv - Ethernet FCS checker over a 4-lane byte stream, IEEE 802.3 CRC-32
// Optional statistics counters (i_clr_stats, o_good_cnt, o_bad_cnt): define CRC32_CHK_STATS_EN
module crc32_chk (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0][7:0] i_data,
  input  logic [1:0]      i_bytes_vld,
  input  logic            i_sop,
  input  logic            i_eop,
  input  logic            i_vld,
`ifdef CRC32_CHK_STATS_EN
  input  logic            i_clr_stats,
  output logic [31:0]     o_good_cnt,
  output logic [31:0]     o_bad_cnt,
`endif
  output logic            o_chk_vld,
  output logic            o_crc_ok,
  output logic            o_runt,
  output logic [31:0]     o_rx_crc,
  output logic [31:0]     o_calc_crc,
  output logic [15:0]     o_pkt_len,
  output logic            o_proto_err
);

  typedef enum logic {S_IDLE, S_IN_PKT} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_crc;
  logic [15:0]     r_len;
  logic [2:0][7:0] r_hold;
  logic            r_chk_vld, r_crc_ok, r_runt, r_proto_err;
  logic [31:0]     r_rx_crc, r_calc_crc;
  logic [15:0]     r_pkt_len;

  logic            w_start, w_cont, w_orphan, w_abort, w_done, w_runt;
  logic [2:0]      w_nv, w_add, w_total, w_nproc;
  logic [7:0]      w_win [0:7];
  logic [31:0]     w_crc, w_rx;
  logic [16:0]     w_len_sum;
  logic [15:0]     w_len;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    v = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++)
      v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
    return v;
  endfunction

  // Window = held bytes (oldest first) followed by this beat; a byte is payload
  // only once at least four bytes are known to follow it.
  always_comb begin
    w_start  = i_vld & i_sop;
    w_cont   = i_vld & ~i_sop & (r_state == S_IN_PKT);
    w_orphan = i_vld & ~i_sop & (r_state == S_IDLE);
    w_abort  = w_start & (r_state == S_IN_PKT);
    w_done   = (w_start | w_cont) & i_eop;
    w_nv     = (i_bytes_vld == 2'd0) ? 3'd4 : {1'b0, i_bytes_vld};
    w_add    = i_eop ? w_nv : 3'd4;
    w_total  = (w_start ? 3'd0 : 3'd3) + w_add;
    if (w_start) begin
      w_win[0] = i_data[3];
      w_win[1] = i_data[2];
      w_win[2] = i_data[1];
      w_win[3] = i_data[0];
      w_win[4] = 8'h00;
      w_win[5] = 8'h00;
      w_win[6] = 8'h00;
    end else begin
      w_win[0] = r_hold[0];
      w_win[1] = r_hold[1];
      w_win[2] = r_hold[2];
      w_win[3] = i_data[3];
      w_win[4] = i_data[2];
      w_win[5] = i_data[1];
      w_win[6] = i_data[0];
    end
    w_win[7] = 8'h00;
    if (!i_eop)
      w_nproc = w_start ? 3'd1 : 3'd4;
    else if (w_total >= 3'd4)
      w_nproc = w_total - 3'd4;
    else
      w_nproc = 3'd0;
    w_crc = w_start ? 32'hFFFFFFFF : r_crc;
    for (int k = 0; k < 4; k++)
      if (3'(k) < w_nproc)
        w_crc = crc_byte(w_crc, w_win[k]);
    w_rx = {w_win[w_total - 3'd1], w_win[w_total - 3'd2],
            w_win[w_total - 3'd3], w_win[w_total - 3'd4]};
    w_len_sum = {1'b0, (w_start ? 16'd0 : r_len)} + {14'd0, w_add};
    w_len     = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];
    w_runt    = (w_len < 16'd4);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_done)
      w_state_nxt = S_IDLE;
    else if (w_start | w_cont)
      w_state_nxt = S_IN_PKT;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc       <= 32'hFFFFFFFF;
      r_len       <= '0;
      r_hold      <= '0;
      r_chk_vld   <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_runt      <= 1'b0;
      r_proto_err <= 1'b0;
      r_rx_crc    <= '0;
      r_calc_crc  <= '0;
      r_pkt_len   <= '0;
    end else begin
      r_chk_vld   <= w_done;
      r_proto_err <= w_orphan | w_abort;
      if (w_done) begin
        r_crc      <= 32'hFFFFFFFF;
        r_len      <= '0;
        r_crc_ok   <= ~w_runt & (w_rx == ~w_crc);
        r_runt     <= w_runt;
        r_rx_crc   <= w_runt ? 32'h0 : w_rx;
        r_calc_crc <= w_runt ? 32'h0 : ~w_crc;
        r_pkt_len  <= w_len;
      end else if (w_start | w_cont) begin
        r_crc     <= w_crc;
        r_len     <= w_len;
        r_hold[0] <= i_data[2];
        r_hold[1] <= i_data[1];
        r_hold[2] <= i_data[0];
      end
    end
  end

  assign o_chk_vld   = r_chk_vld;
  assign o_crc_ok    = r_crc_ok;
  assign o_runt      = r_runt;
  assign o_rx_crc    = r_rx_crc;
  assign o_calc_crc  = r_calc_crc;
  assign o_pkt_len   = r_pkt_len;
  assign o_proto_err = r_proto_err;

`ifdef CRC32_CHK_STATS_EN
  logic [31:0] r_good_cnt, r_bad_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr_stats) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else if (r_chk_vld) begin
      if (r_crc_ok) begin
        if (r_good_cnt != 32'hFFFFFFFF) r_good_cnt <= r_good_cnt + 32'd1;
      end else begin
        if (r_bad_cnt != 32'hFFFFFFFF) r_bad_cnt <= r_bad_cnt + 32'd1;
      end
    end
  end

  assign o_good_cnt = r_good_cnt;
  assign o_bad_cnt  = r_bad_cnt;
`endif

endmodule

// File: tb/tb_crc32_chk.sv
// tb/tb_crc32_chk.sv - self-checking bench for crc32_chk
module tb_crc32_chk;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0][7:0] i_data;
  logic [1:0]      i_bytes_vld;
  logic            i_sop, i_eop, i_vld;
  logic            o_chk_vld, o_crc_ok, o_runt, o_proto_err;
  logic [31:0]     o_rx_crc, o_calc_crc;
  logic [15:0]     o_pkt_len;
`ifdef CRC32_CHK_STATS_EN
  logic            i_clr_stats;
  logic [31:0]     o_good_cnt, o_bad_cnt;
`endif

  crc32_chk dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_bytes_vld(i_bytes_vld),
    .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
`ifdef CRC32_CHK_STATS_EN
    .i_clr_stats(i_clr_stats), .o_good_cnt(o_good_cnt), .o_bad_cnt(o_bad_cnt),
`endif
    .o_chk_vld(o_chk_vld), .o_crc_ok(o_crc_ok), .o_runt(o_runt),
    .o_rx_crc(o_rx_crc), .o_calc_crc(o_calc_crc), .o_pkt_len(o_pkt_len),
    .o_proto_err(o_proto_err)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic        ok;
    logic        runt;
    logic [31:0] rx;
    logic [31:0] calc;
    logic [15:0] len;
  } res_t;

  res_t        res_q[$];
  logic [31:0] exp_calc[$];
  logic [15:0] exp_len[$];
  int          n_proto = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(negedge clk) begin
    res_t r;
    if (o_chk_vld) begin
      r.ok = o_crc_ok; r.runt = o_runt; r.rx = o_rx_crc;
      r.calc = o_calc_crc; r.len = o_pkt_len;
      res_q.push_back(r);
    end
    if (o_proto_err) n_proto++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Non-reflected MSB-first register with bit-reversed input/output
  function automatic logic [31:0] crc_model(input bq_t d);
    logic [31:0] c, r;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < d.size(); i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ d[i][b];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return ~r;
  endfunction

  function automatic bq_t with_fcs(input bq_t p);
    bq_t         q;
    logic [31:0] c;
    q = p;
    c = crc_model(p);
    for (int k = 0; k < 4; k++) q.push_back(c[8*k +: 8]);
    return q;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic idle(input int n);
    i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_pkt(input bq_t pkt, input int gap_pct);
    int n, nb;
    n  = pkt.size();
    nb = (n + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
        i_vld = 1'b0; i_sop = 1'($urandom); i_eop = 1'($urandom); i_data = $urandom;
        @(posedge clk); #1;
      end
      for (int l = 3; l >= 0; l--) begin
        int idx;
        idx = 4*b + (3 - l);
        i_data[l] = (idx < n) ? pkt[idx] : 8'($urandom);
      end
      i_vld = 1'b1;
      i_sop = (b == 0);
      i_eop = (b == nb - 1);
      i_bytes_vld = (b == nb - 1) ? 2'(n % 4) : 2'($urandom);
      @(posedge clk); #1;
    end
    i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic get_res(input string tag, output res_t r);
    int w;
    w = 0;
    while (res_q.size() == 0 && w < 8) begin @(posedge clk); #1; w++; end
    chk({tag, "_present"}, res_q.size() > 0, 1);
    r = (res_q.size() > 0) ? res_q.pop_front() : '0;
  endtask

  task automatic check_stream(input string tag);
    int nbad;
    idle(4);
    chk({tag, "_count"}, res_q.size(), exp_calc.size());
    nbad = 0;
    for (int i = 0; i < exp_calc.size(); i++)
      if (i >= res_q.size() || res_q[i].ok !== 1'b1 || res_q[i].calc !== exp_calc[i] ||
          res_q[i].len !== exp_len[i])
        nbad++;
    chk({tag, "_bad"}, nbad, 0);
    res_q.delete(); exp_calc.delete(); exp_len.delete();
  endtask

  task automatic queue_good(input int plen, input int gap_pct);
    bq_t p;
    p = rand_bytes(plen);
    exp_calc.push_back(crc_model(p));
    exp_len.push_back((plen + 4 > 65535) ? 16'hFFFF : 16'(plen + 4));
    send_pkt(with_fcs(p), gap_pct);
  endtask

  initial begin
    bq_t  pay, pkt;
    res_t r;
    int   p0;

    i_data = '0; i_bytes_vld = '0;
`ifdef CRC32_CHK_STATS_EN
    i_clr_stats = 1'b0;
`endif
    // Reset with a live single-beat packet on the inputs: reset must win.
    rst = 1'b1; i_vld = 1'b1; i_sop = 1'b1; i_eop = 1'b1; i_data = 32'h12345678;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_chk_vld", o_chk_vld, 0);
    chk("rst_crc_ok", o_crc_ok, 0);
    chk("rst_runt", o_runt, 0);
    chk("rst_proto_err", o_proto_err, 0);
    chk("rst_rx_crc", o_rx_crc, 0);
    chk("rst_calc_crc", o_calc_crc, 0);
    chk("rst_pkt_len", o_pkt_len, 0);
    rst = 1'b0;
    idle(2);
    res_q.delete();

    // "123456789" + 26 39 F4 CB
    for (int i = 0; i < 9; i++) pay.push_back(8'(49 + i));
    chk("model_check_value", crc_model(pay), 32'hCBF43926);
    pkt = pay;
    pkt.push_back(8'h26); pkt.push_back(8'h39); pkt.push_back(8'hF4); pkt.push_back(8'hCB);
    send_pkt(pkt, 0);
    chk("s1_latency", o_chk_vld, 1);
    get_res("s1", r);
    chk("s1_pulse", o_chk_vld, 0);
    chk("s1_ok", r.ok, 1);
    chk("s1_calc", r.calc, 32'hCBF43926);
    chk("s1_rx", r.rx, 32'hCBF43926);
    chk("s1_len", r.len, 13);
    chk("s1_runt", r.runt, 0);
`ifdef CRC32_CHK_STATS_EN
    chk("s1_good_cnt", o_good_cnt, 1);
`endif

    // Same packet, payload bit 0 of first byte flipped
    pkt[0] = 8'h30;
    pay[0] = 8'h30;
    send_pkt(pkt, 0);
    get_res("s2", r);
    chk("s2_ok", r.ok, 0);
    chk("s2_rx", r.rx, 32'hCBF43926);
    chk("s2_calc", r.calc, crc_model(pay));
    chk("s2_len", r.len, 13);
`ifdef CRC32_CHK_STATS_EN
    chk("s2_bad_cnt", o_bad_cnt, 1);
    i_clr_stats = 1'b1; @(posedge clk); #1; i_clr_stats = 1'b0;
    chk("clr_good_cnt", o_good_cnt, 0);
    chk("clr_bad_cnt", o_bad_cnt, 0);
`endif

    // Runts of 1..3 bytes
    for (int n = 1; n <= 3; n++) begin
      send_pkt(rand_bytes(n), 0);
      get_res("runt", r);
      chk("runt_flag", r.runt, 1);
      chk("runt_ok", r.ok, 0);
      chk("runt_len", r.len, n);
      chk("runt_rx", r.rx, 0);
      chk("runt_calc", r.calc, 0);
    end

    // Empty payload: four zero bytes pass, other four bytes fail
    pkt.delete();
    repeat (4) pkt.push_back(8'h00);
    send_pkt(pkt, 0);
    get_res("empty0", r);
    chk("empty0_ok", r.ok, 1);
    chk("empty0_runt", r.runt, 0);
    chk("empty0_len", r.len, 4);
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(pkt, 0);
    get_res("empty1", r);
    chk("empty1_ok", r.ok, 0);
    chk("empty1_rx", r.rx, 32'h44332211);
    chk("empty1_calc", r.calc, 0);

    // Sop inside a packet, then orphan beat in idle
    idle(2);
    res_q.delete();
    p0 = n_proto;
    i_data = 32'h31323334; i_vld = 1'b1; i_sop = 1'b1; i_eop = 1'b0;
    @(posedge clk); #1;
    send_pkt(with_fcs(rand_bytes(10)), 0);
    idle(4);
    chk("s4_proto_cnt", n_proto - p0, 1);
    chk("s4_result_cnt", res_q.size(), 1);
    if (res_q.size() > 0) chk("s4_ok", res_q[0].ok, 1);
    res_q.delete();
    p0 = n_proto;
    i_data = 32'hDEADBEEF; i_vld = 1'b1; i_sop = 1'b0; i_eop = 1'b1; i_bytes_vld = 2'd0;
    @(posedge clk); #1;
    idle(3);
    chk("orphan_proto_cnt", n_proto - p0, 1);
    chk("orphan_no_result", res_q.size(), 0);

    // Back-to-back with gaps; reset mid-packet discards one packet silently
    queue_good(5, 30);
    queue_good(8, 0);
    queue_good(3, 30);
    pkt = with_fcs(rand_bytes(20));
    i_vld = 1'b1; i_sop = 1'b1; i_eop = 1'b0;
    i_data = {pkt[0], pkt[1], pkt[2], pkt[3]};
    @(posedge clk); #1;
    i_sop = 1'b0; i_data = {pkt[4], pkt[5], pkt[6], pkt[7]};
    @(posedge clk); #1;
    rst = 1'b1; i_eop = 1'b1; i_bytes_vld = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    queue_good(1, 0);
    queue_good(6, 30);
    queue_good(12, 0);
    check_stream("s5");

    // Loopback over random packets, straddled FCS positions included
    for (int i = 0; i < 300; i++) queue_good($urandom_range(1, 200), 15);
    check_stream("loop");

    // Length saturation beyond 65535 bytes
    queue_good(65536, 0);
    check_stream("sat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
